// File: rtl/md_sequencer_if.sv
// Handshake bundle between CONTROL and the multiply/divide sequencer.
// master: CONTROL side (drives start/op/b_is_zero/abort, observes status and pulses).
// slave:  sequencer side (observes requests, drives busy, launch pulses, mux select, write, done, div0).
interface md_sequencer_if;
    logic start;       // 1-cycle request, sampled only in IDLE
    logic op;          // 0 = MULT, 1 = DIV
    logic b_is_zero;   // divisor == 0, sampled with start
    logic abort;       // cancel operation in progress
    logic busy;        // high in every state except IDLE
    logic mult_start;  // launch pulse to the Multi unit
    logic div_start;   // launch pulse to the DIV unit
    logic md_select;   // 0 = mult result, 1 = div result into HI/LO
    logic hilo_write;  // HI/LO write enable pulse
    logic done;        // completion pulse to CONTROL
    logic div0_exc;    // divide-by-zero exception pulse to CONTROL

    modport master (
        output start, op, b_is_zero, abort,
        input  busy, mult_start, div_start, md_select, hilo_write, done, div0_exc
    );

    modport slave (
        input  start, op, b_is_zero, abort,
        output busy, mult_start, div_start, md_select, hilo_write, done, div0_exc
    );
endinterface

// File: rtl/md_sequencer.sv
// Sequences the Multi/DIV units for CONTROL: launch, count fixed latency, write HI/LO, report done or div0.
// Latency: start at t -> launch pulse t+1, hilo_write t+N+1, done t+N+2 (N = unit cycle count).
// Backpressure: none; start is accepted only in IDLE and dropped otherwise, abort returns to IDLE.
// Ports: clock, reset (sync, active-high), md (md_sequencer_if.slave) carrying the request and status signals.
module md_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic          clock,
    input  logic          reset,
    md_sequencer_if.slave md
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MRUN  = 3'd1,
        S_DRUN  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_DIV0  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;

    logic busy_q, busy_d;
    logic mult_start_q, mult_start_d;
    logic div_start_q, div_start_d;
    logic hilo_write_q, hilo_write_d;
    logic done_q, done_d;
    logic div0_exc_q, div0_exc_d;

    // Next state, counter, select and the output values for the next cycle.
    // Outputs are computed from the next state so that they flop together with
    // it: each output is then a clean registered decode of the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;

        if (md.abort) begin
            // Abort overrides everything, including a start in IDLE.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md.start) begin
                        if (!md.op) begin
                            state_d = S_MRUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            sel_d   = 1'b0;
                        end else if (!md.b_is_zero) begin
                            state_d = S_DRUN;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            sel_d   = 1'b1;
                        end else begin
                            // Divide by zero: no unit launch, no HI/LO write.
                            state_d = S_DIV0;
                            sel_d   = 1'b1;
                        end
                    end
                end
                S_MRUN, S_DRUN: begin
                    if (cnt_q == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WRITE: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                S_DIV0:  state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d       = (state_d != S_IDLE);
        // Launch only on entry from IDLE, i.e. the first cycle of the run state.
        mult_start_d = (state_q == S_IDLE) && (state_d == S_MRUN);
        div_start_d  = (state_q == S_IDLE) && (state_d == S_DRUN);
        hilo_write_d = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        div0_exc_d   = (state_d == S_DIV0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            hilo_write_q <= 1'b0;
            done_q       <= 1'b0;
            div0_exc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            hilo_write_q <= hilo_write_d;
            done_q       <= done_d;
            div0_exc_q   <= div0_exc_d;
        end
    end

    assign md.busy       = busy_q;
    assign md.mult_start = mult_start_q;
    assign md.div_start  = div_start_q;
    assign md.md_select  = sel_q;
    assign md.hilo_write = hilo_write_q;
    assign md.done       = done_q;
    assign md.div0_exc   = div0_exc_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with default 32-cycle units.
// Output vector order in messages: {busy, mult_start, div_start, md_select, hilo_write, done, div0_exc}.
module tb_md_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    md_sequencer_if bus ();

    md_sequencer #(
        .MULT_CYCLES (32),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .md    (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Per-scenario record. Cycle 0 is the cycle start is driven; -1 = never.
    typedef struct {
        logic op;
        logic bz;
        int   abort_at;    // cycle in which abort is driven
        int   restart_at;  // cycle in which a second (ignored) start is driven
        int   ms_at;
        int   ds_at;
        int   d0_at;
        int   hw_at;
        int   done_at;
        int   busy_last;   // busy expected for cycles 1..busy_last (0 = never)
        logic sel_before;
        logic sel_after;
    } vec_t;

    localparam int NVEC = 8;
    localparam int WIN  = 40;
    vec_t vecs [NVEC];

    function automatic logic [6:0] outs();
        return {bus.busy, bus.mult_start, bus.div_start, bus.md_select,
                bus.hilo_write, bus.done, bus.div0_exc};
    endfunction

    task automatic check(input string name, input int vi, input int k,
                         input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d cyc=%0d got=%b want=%b", name, vi, k, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.b_is_zero = 1'b0;
        bus.abort     = 1'b0;
    endtask

    initial begin
        logic [6:0] exp;
        int         base;

        // op, bz, abort, restart, ms, ds, d0, hw, done, busy_last, sel_before, sel_after
        vecs[0] = '{1'b0, 1'b0, -1, -1,  1, -1, -1, 33, 34, 34, 1'b0, 1'b0}; // MULT
        vecs[1] = '{1'b1, 1'b0, -1, -1, -1,  1, -1, 33, 34, 34, 1'b0, 1'b1}; // DIV
        vecs[2] = '{1'b1, 1'b1, -1, -1, -1, -1,  1, -1, -1,  1, 1'b1, 1'b1}; // DIV by zero
        vecs[3] = '{1'b0, 1'b1, -1, -1,  1, -1, -1, 33, 34, 34, 1'b1, 1'b0}; // MULT, bz ignored
        vecs[4] = '{1'b0, 1'b0, 10, -1,  1, -1, -1, -1, -1, 10, 1'b0, 1'b0}; // abort 10th MRUN cycle
        vecs[5] = '{1'b1, 1'b0, -1,  5, -1,  1, -1, 33, 34, 34, 1'b0, 1'b1}; // start again in DRUN
        vecs[6] = '{1'b0, 1'b0,  0, -1, -1, -1, -1, -1, -1,  0, 1'b1, 1'b1}; // start+abort in IDLE
        vecs[7] = '{1'b1, 1'b0, 33, -1, -1,  1, -1, 33, -1, 33, 1'b1, 1'b1}; // abort in WRITE

        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        check("reset_state", -1, 0, outs(), 7'b0);
        reset = 1'b0;
        cyc();
        check("idle_after_reset", -1, 1, outs(), 7'b0);

        // Table-driven scenarios, every cycle of a 40-cycle window compared.
        for (int v = 0; v < NVEC; v++) begin
            for (int k = 0; k < WIN; k++) begin
                exp[6] = (k >= 1) && (k <= vecs[v].busy_last);
                exp[5] = (k == vecs[v].ms_at);
                exp[4] = (k == vecs[v].ds_at);
                exp[3] = (k >= 1) ? vecs[v].sel_after : vecs[v].sel_before;
                exp[2] = (k == vecs[v].hw_at);
                exp[1] = (k == vecs[v].done_at);
                exp[0] = (k == vecs[v].d0_at);
                check("table", v, k, outs(), exp);

                idle_inputs();
                if (k == 0) begin
                    bus.start     = 1'b1;
                    bus.op        = vecs[v].op;
                    bus.b_is_zero = vecs[v].bz;
                end
                if (k == vecs[v].restart_at) begin
                    bus.start     = 1'b1;
                    bus.op        = ~vecs[v].op;
                    bus.b_is_zero = 1'b1;
                end
                if (k == vecs[v].abort_at) bus.abort = 1'b1;
                cyc();
            end
        end
        idle_inputs();

        // Abort mid-MULT, then a DIV start in the very next (IDLE) cycle.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        cyc();                                   // cycle 1
        idle_inputs();
        check("abort_seq_mult_start", -1, 1, outs(), 7'b1100000);
        for (int k = 2; k <= 10; k++) cyc();     // cycle 10
        bus.abort = 1'b1;
        cyc();                                   // cycle 11
        idle_inputs();
        check("abort_seq_idle", -1, 11, outs(), 7'b0);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        cyc();                                   // cycle 12
        idle_inputs();
        check("abort_seq_restart", -1, 12, outs(), 7'b1011000);
        base = 12;
        for (int k = 13; k <= 44; k++) cyc();    // cycle 44 = WRITE
        check("abort_seq_write", -1, 44, outs(), 7'b1001100);
        cyc();                                   // cycle 45 = DONE
        check("abort_seq_done", -1, 45, outs(), 7'b1001010);
        cyc();
        check("abort_seq_idle_sel_held", -1, 46, outs(), 7'b0001000);

        // Reset held two cycles in the middle of a DIV run.
        bus.start = 1'b1;
        bus.op    = 1'b1;
        cyc();
        idle_inputs();
        for (int k = 0; k < 10; k++) cyc();
        check("pre_reset_drun", base, 11, outs(), 7'b1001000);
        reset     = 1'b1;
        bus.start = 1'b1;                        // reset must win over start
        cyc();
        check("reset_mid_drun_1", -1, 0, outs(), 7'b0);
        cyc();
        check("reset_mid_drun_2", -1, 1, outs(), 7'b0);
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("post_reset_quiet", -1, k, outs(), 7'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
